// File: rtl/dmem_access_sequencer_if.sv
// dmem_access_sequencer_if: controller handshake (start/max_iter/hold/busy/done/iter_count/first_iter) plus Dmem read and write beats
interface dmem_access_sequencer_if #(
  parameter int ADDRESSWIDTH = 5,
  parameter int ITERW        = 5
);
  logic                    start;
  logic [ITERW-1:0]        max_iter;
  logic                    hold;
  logic                    rd_en;
  logic [ADDRESSWIDTH-1:0] rd_address;
  logic                    rd_layer;
  logic                    wr_en;
  logic [ADDRESSWIDTH-1:0] wr_address;
  logic                    wr_layer;
  logic                    first_iter;
  logic [ITERW-1:0]        iter_count;
  logic                    busy;
  logic                    done;
  modport master (
    input  start, max_iter, hold,
    output rd_en, rd_address, rd_layer, wr_en, wr_address, wr_layer, first_iter, iter_count, busy, done
  );
  modport slave (
    output start, max_iter, hold,
    input  rd_en, rd_address, rd_layer, wr_en, wr_address, wr_layer, first_iter, iter_count, busy, done
  );
endinterface

// File: rtl/dmem_access_sequencer.sv
// dmem_access_sequencer: issues in-order Dmem read beats per layer and replays them PIPE_LAT cycles later as write beats; ports clk, rst, io_bus (master)
module dmem_access_sequencer #(
  parameter int ADDRESSWIDTH = 5,
  parameter int NCYC         = 20,
  parameter int PIPE_LAT     = 4,
  parameter int ITERW        = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  dmem_access_sequencer_if.master io_bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic                    v;
    logic [ADDRESSWIDTH-1:0] a;
    logic                    l;
  } beat_t;
  localparam logic [ADDRESSWIDTH-1:0] LAST_A = ADDRESSWIDTH'(NCYC - 1);
  state_t                  r_state, w_next;
  beat_t                   r_pipe [PIPE_LAT];
  logic [ADDRESSWIDTH-1:0] r_na, w_a, r_rd_address, r_wr_address;
  logic                    r_nl, w_l, r_rd_layer, r_wr_layer;
  logic [ITERW-1:0]        r_ni, w_i, r_max, w_max, r_iter;
  logic                    w_idle, w_issue, w_wrap, w_last, w_empty;
  logic                    r_rd_en, r_wr_en, r_first, r_busy, r_done;
  always_comb begin
    w_idle  = r_state == IDLE;
    w_a     = w_idle ? '0 : r_na;
    w_l     = w_idle ? 1'b0 : r_nl;
    w_i     = w_idle ? '0 : r_ni;
    w_max   = w_idle ? ((io_bus.max_iter == '0) ? ITERW'(1) : io_bus.max_iter) : r_max;
    w_issue = ~io_bus.hold & (w_idle ? io_bus.start : r_state == RUN);
    w_wrap  = w_a == LAST_A;
    w_last  = w_wrap & w_l & (w_i == w_max - ITERW'(1));
    w_empty = 1'b1;
    for (int k = 0; k < PIPE_LAT; k++)
      if (r_pipe[k].v) w_empty = 1'b0;
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_issue) w_next = w_last ? DRAIN : RUN;
      RUN:   if (w_issue && w_last) w_next = DRAIN;
      DRAIN: if (!io_bus.hold && w_empty) w_next = DONE;
      DONE:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_na         <= '0;
      r_nl         <= 1'b0;
      r_ni         <= '0;
      r_max        <= '0;
      r_rd_en      <= 1'b0;
      r_rd_address <= '0;
      r_rd_layer   <= 1'b0;
      r_iter       <= '0;
      r_first      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_address <= '0;
      r_wr_layer   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int k = 0; k < PIPE_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN) | (w_next == DRAIN);
      r_done  <= w_next == DONE;
      r_rd_en <= w_issue;
      r_first <= w_issue & (w_i == '0);
      if (w_issue) begin
        r_rd_address <= w_a;
        r_rd_layer   <= w_l;
        r_iter       <= w_i;
        r_max        <= w_max;
        r_na         <= w_wrap ? '0 : w_a + ADDRESSWIDTH'(1);
        r_nl         <= w_l ^ w_wrap;
        r_ni         <= w_i + ITERW'(w_wrap & w_l);
      end
      r_wr_en <= ~io_bus.hold & r_pipe[PIPE_LAT-1].v;
      if (!io_bus.hold) begin
        r_pipe[0] <= beat_t'{v: w_issue, a: w_a, l: w_l};
        for (int k = 1; k < PIPE_LAT; k++) r_pipe[k] <= r_pipe[k-1];
        if (r_pipe[PIPE_LAT-1].v) begin
          r_wr_address <= r_pipe[PIPE_LAT-1].a;
          r_wr_layer   <= r_pipe[PIPE_LAT-1].l;
        end
      end
    end
  end
  assign io_bus.rd_en      = r_rd_en;
  assign io_bus.rd_address = r_rd_address;
  assign io_bus.rd_layer   = r_rd_layer;
  assign io_bus.wr_en      = r_wr_en;
  assign io_bus.wr_address = r_wr_address;
  assign io_bus.wr_layer   = r_wr_layer;
  assign io_bus.first_iter = r_first;
  assign io_bus.iter_count = r_iter;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
endmodule

// File: tb/tb_dmem_access_sequencer.sv
// tb_dmem_access_sequencer: directed self-checking bench for dmem_access_sequencer
module tb_dmem_access_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  dmem_access_sequencer_if #(.ADDRESSWIDTH(5), .ITERW(5)) bus ();
  dmem_access_sequencer #(.ADDRESSWIDTH(5), .NCYC(20), .PIPE_LAT(4), .ITERW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
    chk({tag, "_rd_addr"}, int'(bus.rd_address), 0);
    chk({tag, "_rd_layer"}, int'(bus.rd_layer), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, int'(bus.wr_address), 0);
    chk({tag, "_wr_layer"}, int'(bus.wr_layer), 0);
    chk({tag, "_first"}, int'(bus.first_iter), 0);
    chk({tag, "_iter"}, int'(bus.iter_count), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask
  task automatic run(input int mi, input int nbeats, input int done_at, input bit do_hold, input bit keep_start);
    int rc, wc, done_cyc, hcnt;
    bit h1, h2;
    rc = 0; wc = 0; done_cyc = -1; hcnt = 0; h1 = 0; h2 = 0;
    @(negedge clk);
    bus.max_iter = 5'(mi);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= done_at + 20 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (!keep_start) bus.start = 1'b0;
      if (bus.rd_en) begin
        chk("rd_addr", int'(bus.rd_address), rc % 20);
        chk("rd_layer", int'(bus.rd_layer), (rc / 20) % 2);
        chk("iter_count", int'(bus.iter_count), rc / 40);
        chk("first_iter", int'(bus.first_iter), int'(rc < 40));
        rc++;
      end else chk("first_idle", int'(bus.first_iter), 0);
      if (bus.wr_en) begin
        chk("wr_addr", int'(bus.wr_address), wc % 20);
        chk("wr_layer", int'(bus.wr_layer), (wc / 20) % 2);
        wc++;
      end
      chk("busy", int'(bus.busy), int'(cyc < done_at));
      if (bus.done) done_cyc = cyc;
      if (do_hold && rc == 10 && !h1) begin h1 = 1; hcnt = 3; end
      if (do_hold && rc == nbeats && !h2) begin h2 = 1; hcnt = 3; end
      bus.hold = hcnt > 0;
      if (hcnt > 0) hcnt--;
    end
    bus.hold = 1'b0;
    chk("done_cycle", done_cyc, done_at);
    chk("rd_beats", rc, nbeats);
    chk("wr_beats", wc, nbeats);
  endtask
  initial begin
    int rc, dn;
    bus.start = 1'b0;
    bus.max_iter = '0;
    bus.hold = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle");
    run(1, 40, 45, 0, 0);
    run(3, 120, 125, 0, 0);
    run(0, 40, 45, 0, 0);
    run(1, 40, 51, 1, 0);
    @(negedge clk);
    bus.max_iter = 5'd2;
    bus.start = 1'b1;
    rc = 0;
    for (int cyc = 0; cyc < 60 && rc < 25; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.rd_en) rc++;
    end
    chk("beats_before_rst", rc, 25);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrun_rst");
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_rd", int'(bus.rd_en), 0);
      chk("post_rst_wr", int'(bus.wr_en), 0);
    end
    run(1, 40, 45, 0, 0);
    run(1, 40, 45, 0, 1);
    @(negedge clk);
    chk("idle_gap_rd", int'(bus.rd_en), 0);
    chk("idle_gap_busy", int'(bus.busy), 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("rerun_rd", int'(bus.rd_en), 1);
    chk("rerun_addr", int'(bus.rd_address), 0);
    chk("rerun_iter", int'(bus.iter_count), 0);
    dn = 0;
    for (int cyc = 0; cyc < 100 && dn == 0; cyc++) begin
      @(negedge clk);
      if (bus.done) dn = cyc + 2;
    end
    chk("rerun_done", dn, 45);
    repeat (3) @(negedge clk);
    chk("final_idle", int'(bus.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_sequencer.md
Name: dmem_access_sequencer

Overview:
- Initiator that drives the read/write side of the D shift-register-queue memory in the layered LDPC decoder.
- Issues in-order read beats per layer: rd_en, rd_address, rd_layer.
- Re-issues each beat PIPE_LAT cycles later as a write beat (wr_en, plus wr_address/wr_layer for checking), matching row-calculation-unit latency so queue order is preserved.
- Owns the iteration count and the start/busy/done handshake with the decoder top-level controller.

Parameters:
- ADDRESSWIDTH, 5, width of rd_address/wr_address.
- NCYC, 20, beats per layer (ceil(Z/P) = ceil(511/26)); must be ≤ 2^ADDRESSWIDTH.
- PIPE_LAT, 4, read-beat to write-beat delay in cycles; ≥ 1.
- ITERW, 5, width of max_iter and iter_count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin decode; sampled in IDLE only.
- max_iter  in  ITERW  iterations to run; latched on accepted start; 0 treated as 1.
- hold  in  1  stall: freezes read issue and write pipeline.
- rd_en  out  1  read beat to Dmem.
- rd_address  out  ADDRESSWIDTH  reaccess address, 0..NCYC-1.
- rd_layer  out  1  layer of current read beat.
- wr_en  out  1  write beat to Dmem.
- wr_address  out  ADDRESSWIDTH  address of write beat (debug/check).
- wr_layer  out  1  layer of write beat.
- first_iter  out  1  high with rd_en during iteration 0; D read data is invalid, row unit uses zero.
- iter_count  out  ITERW  current read iteration.
- busy  out  1  high from RUN entry until the done cycle.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, write pipeline cleared. rst wins over every other input, including mid-run; no further beats are issued after reset.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, latch max_iter (0→1), clear counters, go to RUN.
  - start is ignored in every other state.
- RUN, each cycle with hold=0:
  - rd_en=1 with current address/layer; address increments.
  - At address NCYC-1, address wraps to 0 and rd_layer toggles.
  - At wrap with layer 1, iter_count increments.
  - After the last beat (iter = max-1, layer 1, address NCYC-1), go to DRAIN.
- Write pipeline:
  - PIPE_LAT-stage shift register of {valid, address, layer}, fed by read beats.
  - wr_en/wr_address/wr_layer = stage output.
  - A write beat appears exactly PIPE_LAT non-held cycles after its read beat.
- hold=1, any state:
  - rd_en=0 and wr_en=0.
  - Address, layer, iteration and pipeline contents frozen; FSM does not advance.
  - Released beats resume with no loss or duplication.
- DRAIN:
  - No reads issued.
  - When the pipeline holds no valid beats (last wr_en issued), go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start in the DONE cycle is ignored.
- first_iter = rd_en & (iter_count==0).
- Totals per run: read beats = 2·NCYC·max_iter; write beats equal, in identical order.

Test Plan:
- Defaults, max_iter=1, start pulsed in cycle T → rd_en high T+1..T+40; addresses 0..19 layer 0, then 0..19 layer 1; first_iter high throughout. wr_en high T+5..T+44 with the same address/layer sequence. done in T+45; busy high T+1..T+44.
- max_iter=3 → 120 read and 120 write beats. iter_count 0,1,2, each step at the layer-1 wrap. first_iter only on the first 40 beats. done at T+125.
- max_iter=0 → behaves exactly as max_iter=1 (40 beats, done at T+45).
- hold high for 3 cycles at read beat 10, then 3 cycles during DRAIN → rd_en/wr_en low while held; no skipped or repeated address; done delayed by 6 cycles (T+51).
- rst asserted at read beat 25 → next cycle all outputs 0. A new start runs cleanly from address 0, layer 0, iteration 0.
- start held high through the run and the DONE cycle → exactly one run. With start still high, a second run begins only after IDLE is re-entered.
